// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package sseg_pkg;

   localparam int NDIGITS = 8;

   typedef logic [6:0] seg_t;

   // Active-high segment patterns, bit 0 = a ... bit 6 = g.
   localparam seg_t HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C,
      7'h39, 7'h5E, 7'h79, 7'h71
   };

   // One complete frame of display data.
   typedef struct packed {
      logic [4*NDIGITS-1:0] val;
      logic [NDIGITS-1:0]   dp;
      logic [NDIGITS-1:0]   en;
   } frame_t;

endpackage

// File: rtl/sseg_scan_if.sv
// Core-side load bus and display pins of the seven-segment scan driver.
interface sseg_scan_if;
   import sseg_pkg::*;

   logic                 load;
   logic [4*NDIGITS-1:0] value;
   logic [NDIGITS-1:0]   dp_in;
   logic [NDIGITS-1:0]   en_in;
   logic [NDIGITS-1:0]   an;
   seg_t                 seg;
   logic                 dp;
   logic                 frame_tick;

   modport master (
      output load, value, dp_in, en_in,
      input  an, seg, dp, frame_tick
   );

   modport slave (
      input  load, value, dp_in, en_in,
      output an, seg, dp, frame_tick
   );

endinterface

// File: rtl/sseg_scan_hex7seg.sv
// Combinational hex nibble to active-high segment pattern decoder.
module hex7seg
   import sseg_pkg::*;
(
   input  logic [3:0] nibble,
   output seg_t       seg_on
);

   assign seg_on = HEX_SEG[nibble];

endmodule

// File: rtl/sseg_scan.sv
// Eight-digit multiplexed seven-segment driver with blanking and
// frame-synchronous data update.
module sseg_scan
   import sseg_pkg::*;
#(
   parameter int N     = 17,
   parameter int BLANK = 1024
)(
   input  logic        clk,
   input  logic        reset,
   sseg_scan_if.slave  bus
);

   localparam logic [N-1:0] Q_MAX   = '1;
   localparam logic [N:0]   BLANK_V = (N+1)'(BLANK);

   logic [N-1:0]         q;
   logic [2:0]           d;
   logic                 boundary;
   logic                 pend;
   frame_t               pend_set;
   frame_t               act_set;
   frame_t               in_set;
   logic [3:0]           cur_nib;
   seg_t                 cur_seg;
   logic                 lit;
   logic [NDIGITS-1:0]   an_r;
   seg_t                 seg_r;
   logic                 dp_r;
   logic                 tick_r;

   assign in_set   = '{val: bus.value, dp: bus.dp_in, en: bus.en_in};
   assign boundary = (d == 3'd7) && (q == Q_MAX);
   assign cur_nib  = act_set.val[{d, 2'b00} +: 4];
   assign lit      = ({1'b0, q} >= BLANK_V) && act_set.en[d];

   hex7seg u_hex (
      .nibble (cur_nib),
      .seg_on (cur_seg)
   );

   // Slot prescaler and digit index; the digit advances on the last slot cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
         d <= '0;
      end else begin
         q <= q + 1'b1;
         if (q == Q_MAX)
            d <= d + 3'd1;
      end
   end

   // Pending capture: loads outside the boundary cycle wait here, last one wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend     <= 1'b0;
         pend_set <= '0;
      end else if (boundary) begin
         pend     <= 1'b0;
      end else if (bus.load) begin
         pend     <= 1'b1;
         pend_set <= in_set;
      end
   end

   // Active set changes only at the frame boundary; a load in that cycle wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         act_set <= '0;
      end else if (boundary) begin
         if (bus.load)
            act_set <= in_set;
         else if (pend)
            act_set <= pend_set;
      end
   end

   // Registered display pins and frame tick; dark during blanking or disabled digit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an_r   <= '1;
         seg_r  <= '1;
         dp_r   <= 1'b1;
         tick_r <= 1'b0;
      end else begin
         an_r   <= lit ? ~(8'd1 << d) : 8'hFF;
         seg_r  <= lit ? ~cur_seg : 7'h7F;
         dp_r   <= lit ? ~act_set.dp[d] : 1'b1;
         tick_r <= boundary && (bus.load || pend);
      end
   end

   assign bus.an         = an_r;
   assign bus.seg        = seg_r;
   assign bus.dp         = dp_r;
   assign bus.frame_tick = tick_r;

endmodule

// File: tb/tb_sseg_scan.sv
// Bench for sseg_scan with N=2, BLANK=1 (4-cycle slots, 32-cycle frames).
module tb_sseg_scan;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   sseg_scan_if bus ();

   sseg_scan #(.N(2), .BLANK(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit started  = 1'b0;

   // Lit segments per hex digit, bit 0 = a ... bit 6 = g.
   logic [6:0] lit_tab [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
   };

   logic [31:0] m_act_val, m_pen_val;
   logic [7:0]  m_act_dp, m_act_en, m_pen_dp, m_pen_en;
   bit          m_pend;
   logic [7:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp, e_tick;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h cyc=%0d", name, got, exp, cyc);
      end
   endtask

   // Pin both the DUT and the model to a hand-derived value.
   task automatic pin(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                      input logic [31:0] lit_v);
      chk({name, "_dut"}, dut_v, lit_v);
      chk({name, "_model"}, mdl_v, lit_v);
   endtask

   task automatic model_step();
      int pos, dd, qq;
      if (reset) begin
         m_act_val = '0; m_act_dp = '0; m_act_en = '0;
         m_pen_val = '0; m_pen_dp = '0; m_pen_en = '0;
         m_pend = 1'b0;
         e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
         cyc = 0;
         started = 1'b1;
      end else begin
         pos = cyc % 32;
         dd  = pos / 4;
         qq  = pos % 4;
         if (qq >= 1 && m_act_en[dd]) begin
            e_an  = 8'hFF & ~(8'd1 << dd);
            e_seg = ~lit_tab[m_act_val[dd*4 +: 4]];
            e_dp  = ~m_act_dp[dd];
         end else begin
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
         end
         e_tick = 1'b0;
         if (pos == 31) begin
            if (bus.load) begin
               m_act_val = bus.value; m_act_dp = bus.dp_in; m_act_en = bus.en_in;
               e_tick = 1'b1;
            end else if (m_pend) begin
               m_act_val = m_pen_val; m_act_dp = m_pen_dp; m_act_en = m_pen_en;
               e_tick = 1'b1;
            end
            m_pend = 1'b0;
         end else if (bus.load) begin
            m_pen_val = bus.value; m_pen_dp = bus.dp_in; m_pen_en = bus.en_in;
            m_pend = 1'b1;
         end
         cyc++;
      end
   endtask

   // Reference model advances on every clock edge and on reset assertion.
   initial begin
      forever begin
         @(posedge clk or posedge reset);
         model_step();
      end
   end

   // Continuous compare of DUT pins against the model, away from the clock edge.
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            chk("an", bus.an, e_an);
            chk("seg", bus.seg, e_seg);
            chk("dp", bus.dp, e_dp);
            chk("frame_tick", bus.frame_tick, e_tick);
            chk("one_anode", ($countones(~bus.an) <= 1), 1'b1);
         end
      end
   end

   task automatic wait_pos(input int p);
      do @(negedge clk); while (cyc % 32 != p);
   endtask

   task automatic do_load(input logic [31:0] v, input logic [7:0] dpv, input logic [7:0] env);
      bus.load = 1'b1; bus.value = v; bus.dp_in = dpv; bus.en_in = env;
      @(negedge clk);
      bus.load = 1'b0;
   endtask

   initial begin
      bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.en_in = '0;

      // Reset held, then idle: display must stay dark.
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      pin("rst_an", bus.an, e_an, 8'hFF);
      pin("rst_seg", bus.seg, e_seg, 7'h7F);

      // First frame.
      wait_pos(5);
      do_load(32'h76543210, 8'h01, 8'hFF);
      wait_pos(0);
      pin("ff_tick", bus.frame_tick, e_tick, 1'b1);
      wait_pos(1);
      pin("ff_blank_an", bus.an, e_an, 8'hFF);
      wait_pos(2);
      pin("ff_d0_an", bus.an, e_an, 8'hFE);
      pin("ff_d0_seg", bus.seg, e_seg, 7'h40);
      pin("ff_d0_dp", bus.dp, e_dp, 1'b0);
      wait_pos(6);
      pin("ff_d1_an", bus.an, e_an, 8'hFD);
      pin("ff_d1_seg", bus.seg, e_seg, 7'h79);
      pin("ff_d1_dp", bus.dp, e_dp, 1'b1);

      // Mid-frame reloads: last one wins, applied only at the next frame.
      wait_pos(12);
      do_load(32'hFFFFFFFF, 8'h00, 8'hFF);
      wait_pos(20);
      do_load(32'h00000000, 8'h00, 8'hFF);
      wait_pos(27);
      pin("mf_d6_seg", bus.seg, e_seg, 7'h02);
      pin("mf_d6_an", bus.an, e_an, 8'hBF);
      wait_pos(15);
      pin("mf_d3_seg", bus.seg, e_seg, 7'h40);
      pin("mf_d3_an", bus.an, e_an, 8'hF7);

      // Load exactly in the boundary cycle.
      wait_pos(31);
      do_load(32'h0000000A, 8'h00, 8'hFF);
      pin("lb_tick", bus.frame_tick, e_tick, 1'b1);
      wait_pos(2);
      pin("lb_d0_seg", bus.seg, e_seg, 7'h08);
      pin("lb_d0_an", bus.an, e_an, 8'hFE);

      // Enable mask: upper digits dark but still occupy their slots.
      wait_pos(3);
      do_load(32'h12345678, 8'hF0, 8'h0F);
      repeat (32) @(negedge clk);
      wait_pos(23);
      pin("en_d5_an", bus.an, e_an, 8'hFF);
      wait_pos(11);
      pin("en_d2_an", bus.an, e_an, 8'hFB);
      repeat (32) @(negedge clk);

      // Randomized loads across many frames.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            bus.load  = 1'b1;
            bus.value = $urandom;
            bus.dp_in = 8'($urandom);
            bus.en_in = 8'($urandom);
         end else begin
            bus.load = 1'b0;
         end
         @(negedge clk);
      end
      bus.load = 1'b0;

      // Reset mid-frame drops pending data.
      wait_pos(3);
      do_load(32'h89ABCDEF, 8'hFF, 8'hFF);
      wait_pos(9);
      #2 reset = 1'b1;
      #1;
      pin("rmf_an", bus.an, e_an, 8'hFF);
      pin("rmf_seg", bus.seg, e_seg, 7'h7F);
      pin("rmf_dp", bus.dp, e_dp, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      repeat (66) @(negedge clk);
      pin("rmf_dark_an", bus.an, e_an, 8'hFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
